id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; SHALL equal bus_type width.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have if_valid  input  1, if_instr  input  32, if_pc  input  XLEN  fetched instruction with valid/ready handshake.
REQ-005 SHALL have if_ready  output  1  stage accepts instruction this cycle.
REQ-006 SHALL have rf_raddr1, rf_raddr2  output  5 each  register file read addresses.
REQ-007 SHALL have rf_rdata1, rf_rdata2  input  XLEN each  register file read data; x0 reads zero.
REQ-008 SHALL have wb_valid  input  1, wb_addr  input  5, wb_data  input  XLEN  the writeback driving the register file write port.
REQ-009 SHALL have ex_valid  output  1, ex_ready  input  1  downstream handshake.
REQ-010 SHALL have ex_pc  output  XLEN, ex_opcode  output  7, ex_funct3  output  3, ex_funct7  output  7, ex_rd  output  5, ex_rs1_val, ex_rs2_val, ex_imm  output  XLEN  registered ID/EX fields.

Function
REQ-011 rf_raddr1 SHALL be if_instr[19:15] and rf_raddr2 SHALL be if_instr[24:20], combinational.
REQ-012 Decode SHALL classify opcode: R 0110011, I 0010011/0000011/1100111/1110011, S 0100011, B 1100011, U 0110111/0010111, J 1101111; other opcodes: no source use, no rd write, imm 0.
REQ-013 uses_rs1 SHALL be true for R, I, S, B; uses_rs2 SHALL be true for R, S, B only.
REQ-014 writes_rd SHALL be true for R, I, U, J with rd != 0.
REQ-015 ex_imm SHALL be the sign-extended RV32I immediate per format (I, S, B, U, J); R-type imm 0.
REQ-016 A 32-entry scoreboard SHALL hold one pending-write bit per register; bit 0 SHALL always read 0.
REQ-017 stall SHALL be asserted when a used nonzero source, or rd when writes_rd (WAW), has its scoreboard bit set.
REQ-018 if_ready SHALL equal !stall && (!ex_valid || ex_ready), combinationally.
REQ-019 Issue (if_valid && if_ready) SHALL load all ex_* fields from decode and rf_rdata*, set ex_valid=1, and set scoreboard[rd] if writes_rd; latency 1 cycle.
REQ-020 ex_valid && !ex_ready SHALL hold all ex_* fields stable.
REQ-021 ex_ready without issue SHALL clear ex_valid next cycle; other ex_* fields may hold.
REQ-022 wb_valid with wb_addr != 0 SHALL clear scoreboard[wb_addr]; wb_addr 0 ignored.
REQ-023 Same-cycle set and clear of the same index SHALL leave the bit set.
REQ-024 Without bypass, a stalled instruction SHALL issue the cycle after its blocking writeback, reading the updated register file.
REQ-025 rd and rs equal (e.g. addi x5,x5,1) SHALL check rs against pre-issue scoreboard state.

Reset
REQ-026 rst SHALL clear scoreboard, ex_valid and all ex_* fields to 0 on the next edge, overriding issue and writeback in that cycle.
REQ-027 During rst, if_ready SHALL be 0.
REQ-028 Reset mid-stall SHALL discard the held instruction; upstream re-presents it.

Configuration
REQ-029 Macro WB_BYPASS_EN SHALL, when defined, treat a source or WAW hazard as resolved when wb_valid && wb_addr matches it, selecting wb_data as the operand that cycle.
REQ-030 Without WB_BYPASS_EN, operands SHALL come only from rf_rdata*, and hazards resolve per REQ-024.

Verification
REQ-031 Reset then addi x1,x0,5 with ex_ready=1 -> ex_valid=1 next cycle, ex_rd=1, ex_imm=5, scoreboard[1]=1.
REQ-032 add x3,x1,x2 while scoreboard[1] set -> if_ready=0; wb_valid, wb_addr=1, wb_data=7 -> issue next cycle (no bypass) or same cycle with ex_rs1_val=7 (bypass).
REQ-033 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, if_ready=0.
REQ-034 sw x2,-4(x1) -> ex_imm=0xFFFFFFFC, no scoreboard set; beq imm -8 -> ex_imm=0xFFFFFFF8.
REQ-035 Issue addi x4 same cycle as wb_addr=4 -> scoreboard[4]=1; wb_addr=0 -> no change.
REQ-036 rst asserted while stalled with ex_valid=1 -> next cycle ex_valid=0, scoreboard all 0.

Source files
------------

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode/issue stage with register scoreboard and ID/EX register.
// Optional macro WB_BYPASS_EN: resolve hazards against the same-cycle writeback and forward wb_data.
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm
);

  typedef enum logic [2:0] {
    C_NONE, C_R, C_I, C_S, C_B, C_U, C_J
  } iclass_t;

  logic [6:0]       opcode;
  logic [4:0]       rs1, rs2, rd;
  iclass_t          iclass;
  logic             uses_rs1, uses_rs2, writes_rd;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]  imm_x;

  logic             byp1, byp2, bypd;
  logic             haz_rs1, haz_rs2, haz_rd, stall, issue;
  logic [XLEN-1:0]  op1, op2;

  logic [31:0]      sb_q, sb_d;
  logic             ex_valid_q;
  logic [XLEN-1:0]  ex_pc_q, ex_rs1_val_q, ex_rs2_val_q, ex_imm_q;
  logic [6:0]       ex_opcode_q, ex_funct7_q;
  logic [2:0]       ex_funct3_q;
  logic [4:0]       ex_rd_q;

  assign opcode    = if_instr[6:0];
  assign rd        = if_instr[11:7];
  assign rs1       = if_instr[19:15];
  assign rs2       = if_instr[24:20];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  always_comb begin
    iclass = C_NONE;
    case (opcode)
      7'b0110011:                                     iclass = C_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: iclass = C_I;
      7'b0100011:                                     iclass = C_S;
      7'b1100011:                                     iclass = C_B;
      7'b0110111, 7'b0010111:                         iclass = C_U;
      7'b1101111:                                     iclass = C_J;
      default:                                        iclass = C_NONE;
    endcase
  end

  assign uses_rs1  = (iclass == C_R) || (iclass == C_I) || (iclass == C_S) || (iclass == C_B);
  assign uses_rs2  = (iclass == C_R) || (iclass == C_S) || (iclass == C_B);
  assign writes_rd = ((iclass == C_R) || (iclass == C_I) || (iclass == C_U) || (iclass == C_J))
                     && (rd != 5'd0);

  always_comb begin
    imm32 = '0;
    case (iclass)
      C_I: imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
      C_S: imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      C_B: imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                    if_instr[11:8], 1'b0};
      C_U: imm32 = {if_instr[31:12], 12'b0};
      C_J: imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                    if_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed source makes the width cast sign-extend when XLEN exceeds 32.
  assign imm_x = XLEN'(imm32);

`ifdef WB_BYPASS_EN
  assign byp1 = wb_valid && (wb_addr == rs1) && (rs1 != 5'd0);
  assign byp2 = wb_valid && (wb_addr == rs2) && (rs2 != 5'd0);
  assign bypd = wb_valid && (wb_addr == rd) && (rd != 5'd0);
  assign op1  = byp1 ? wb_data : rf_rdata1;
  assign op2  = byp2 ? wb_data : rf_rdata2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign bypd = 1'b0;
  assign op1  = rf_rdata1;
  assign op2  = rf_rdata2;
`endif

  // Hazards look at the scoreboard before this instruction's own rd is marked.
  assign haz_rs1 = uses_rs1 && (rs1 != 5'd0) && sb_q[rs1] && !byp1;
  assign haz_rs2 = uses_rs2 && (rs2 != 5'd0) && sb_q[rs2] && !byp2;
  assign haz_rd  = writes_rd && sb_q[rd] && !bypd;
  assign stall   = haz_rs1 || haz_rs2 || haz_rd;

  assign if_ready = !rst && !stall && (!ex_valid_q || ex_ready);
  assign issue    = if_valid && if_ready;

  // Clear first, then set, so a same-cycle issue to the written index wins.
  always_comb begin
    sb_d = sb_q;
    if (wb_valid && (wb_addr != 5'd0)) sb_d[wb_addr] = 1'b0;
    if (issue && writes_rd)            sb_d[rd]      = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q         <= '0;
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_opcode_q  <= '0;
      ex_funct3_q  <= '0;
      ex_funct7_q  <= '0;
      ex_rd_q      <= '0;
      ex_rs1_val_q <= '0;
      ex_rs2_val_q <= '0;
      ex_imm_q     <= '0;
    end else begin
      sb_q <= sb_d;
      if (issue) begin
        ex_valid_q   <= 1'b1;
        ex_pc_q      <= if_pc;
        ex_opcode_q  <= opcode;
        ex_funct3_q  <= if_instr[14:12];
        ex_funct7_q  <= if_instr[31:25];
        ex_rd_q      <= rd;
        ex_rs1_val_q <= op1;
        ex_rs2_val_q <= op2;
        ex_imm_q     <= imm_x;
      end else if (ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_opcode  = ex_opcode_q;
  assign ex_funct3  = ex_funct3_q;
  assign ex_funct7  = ex_funct7_q;
  assign ex_rd      = ex_rd_q;
  assign ex_rs1_val = ex_rs1_val_q;
  assign ex_rs2_val = ex_rs2_val_q;
  assign ex_imm     = ex_imm_q;

endmodule
